// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The optional branch predecode is enabled by defining FETCH_PREDECODE_B_EN.
package fetch_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam logic [5:0] OPC_B = 6'b000101;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               pred_taken;
    } fetch_entry_t;

    // Target of an unconditional B: pc + sign-extended imm26 in words.
    function automatic logic [PC_W-1:0] b_target(input logic [PC_W-1:0]    pc,
                                                 input logic [INSTR_W-1:0] instr);
        return pc + {{(PC_W-28){instr[25]}}, instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory port, redirect input and decode handshake.
// The master modport is the fetch unit itself.
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic [PC_W-1:0]            imem_addr;
    logic [INSTR_W-1:0]         imem_rdata;
    logic                       redirect_valid;
    logic [PC_W-1:0]            redirect_pc;
    logic                       out_valid;
    logic                       out_ready;
    logic [INSTR_W-1:0]         out_instr;
    logic [PC_W-1:0]            out_pc;
    logic [PC_W-1:0]            out_basicAddress;
    logic                       out_pred_taken;
    logic [$clog2(DEPTH+1)-1:0] occupancy;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, out_basicAddress,
               out_pred_taken, occupancy,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, out_basicAddress,
               out_pred_taken, occupancy,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr, pred_taken} entries.
// Callers guarantee push only when not full or popping in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wr_entry,
    output fetch_entry_t               head_entry,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail] <= wr_entry;
                tail      <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_entry = mem[head];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection and decode-side queue.
// Define FETCH_PREDECODE_B_EN to follow unconditional B instructions at fetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  bus
);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  next_pc;
    logic             pred;
    logic             push;
    logic             pop;
    logic             full;
    logic [CNT_W-1:0] count;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head_entry;
    logic             unused_redirect_lsb;

    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    assign full = (count == CNT_W'(DEPTH));
    assign pop  = bus.out_valid & bus.out_ready;
    // A full queue still fetches when decode drains the head this cycle.
    assign push = !reset & !bus.redirect_valid & (!full | pop);

    always_comb begin
        pred    = 1'b0;
        next_pc = pc + PC_W'(4);
`ifdef FETCH_PREDECODE_B_EN
        if (bus.imem_rdata[31:26] == OPC_B) begin
            pred    = 1'b1;
            next_pc = b_target(pc, bus.imem_rdata);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (bus.redirect_valid) begin
            pc <= {bus.redirect_pc[PC_W-1:2], 2'b00};
        end else if (push) begin
            pc <= next_pc;
        end
    end

    assign wr_entry = '{pc: pc, instr: bus.imem_rdata, pred_taken: pred};

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (bus.redirect_valid),
        .wr_entry   (wr_entry),
        .head_entry (head_entry),
        .count      (count)
    );

    assign bus.imem_addr        = pc;
    assign bus.out_valid        = (count != '0);
    assign bus.out_instr        = head_entry.instr;
    assign bus.out_pc           = head_entry.pc;
    assign bus.out_basicAddress = head_entry.pc + PC_W'(4);
    assign bus.out_pred_taken   = head_entry.pred_taken;
    assign bus.occupancy        = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-level reference model predicts every
// delivered entry; a negedge monitor compares whatever the DUT presents.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic clk;
    logic reset;

    fetch_unit_if #(.DEPTH(DEPTH)) bus ();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int           checks = 0;
    int           errors = 0;
    fetch_entry_t exp_q[$];
    logic [63:0]  mpc;
    bit           mon_en = 0;
    bit           b_at_8 = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [63:0] a, input bit b8);
        if (b8 && a == 64'h8) return 32'h14000004;
        return a[31:0];
    endfunction

    always_comb bus.imem_rdata = mem_word(bus.imem_addr, b_at_8);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit rv, input logic [63:0] rpc, input bit rdy);
        reset              = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
    endtask

    // Reference model of one clock edge; the monitor has already removed any
    // entry handed to decode this cycle, so a fetch happens whenever room remains.
    task automatic model_edge();
        logic [31:0] w;
        logic        pt;
        logic [63:0] nx;
        if (reset) begin
            exp_q.delete();
            mpc = RESET_PC;
        end else if (bus.redirect_valid) begin
            exp_q.delete();
            mpc = bus.redirect_pc & ~64'h3;
        end else if (exp_q.size() < DEPTH) begin
            w  = mem_word(mpc, b_at_8);
`ifdef FETCH_PREDECODE_B_EN
            pt = (w[31:26] == 6'b000101);
`else
            pt = 1'b0;
`endif
            nx = pt ? mpc + 64'($signed(w[25:0])) * 64'd4 : mpc + 64'd4;
            exp_q.push_back('{pc: mpc, instr: w, pred_taken: pt});
            mpc = nx;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            check("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
            check("imem_addr", bus.imem_addr, mpc);
            if (exp_q.size() != 0) begin
                check("out_pc", bus.out_pc, exp_q[0].pc);
                check("out_instr", 64'(bus.out_instr), 64'(exp_q[0].instr));
                check("out_basicAddress", bus.out_basicAddress, exp_q[0].pc + 64'd4);
                check("out_pred_taken", 64'(bus.out_pred_taken), 64'(exp_q[0].pred_taken));
                if (bus.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_occ"}, 64'(bus.occupancy), 64'd0);
        check({tag, "_instr"}, 64'(bus.out_instr), 64'd0);
        check({tag, "_pc"}, bus.out_pc, 64'd0);
        check({tag, "_basic"}, bus.out_basicAddress, 64'd4);
        check({tag, "_pred"}, 64'(bus.out_pred_taken), 64'd0);
    endtask

    initial begin
        drive(1, 0, 64'h0, 0);
        tick();
        mon_en = 1;
        tick();
        check_reset_outputs("rst");
        check("rst_imem_addr", bus.imem_addr, RESET_PC);

        // streaming
        drive(0, 0, 64'h0, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stream_valid", 64'(bus.out_valid), 64'd1);
            check("stream_pc", bus.out_pc, 64'(i * 4));
            check("stream_basic", bus.out_basicAddress, 64'(i * 4 + 4));
            check("stream_instr", 64'(bus.out_instr), 64'(i * 4));
        end

        // backpressure
        drive(1, 0, 64'h0, 0);
        tick();
        drive(0, 0, 64'h0, 0);
        for (int i = 0; i < 6; i++) tick();
        check("bp_occ_full", 64'(bus.occupancy), 64'd4);
        check("bp_addr_held", bus.imem_addr, 64'h10);
        drive(0, 0, 64'h0, 1);
        for (int i = 0; i < 6; i++) begin
            check("bp_drain_pc", bus.out_pc, 64'(i * 4));
            check("bp_drain_occ", 64'(bus.occupancy), 64'd4);
            tick();
        end

        // redirect with entries queued
        drive(1, 0, 64'h0, 0);
        tick();
        drive(0, 0, 64'h0, 0);
        for (int i = 0; i < 3; i++) tick();
        check("redir_pre_occ", 64'(bus.occupancy), 64'd3);
        drive(0, 1, 64'h400, 1);
        tick();
        check("redir_valid", 64'(bus.out_valid), 64'd0);
        check("redir_occ", 64'(bus.occupancy), 64'd0);
        drive(0, 0, 64'h0, 1);
        tick();
        check("redir_pc0", bus.out_pc, 64'h400);
        tick();
        check("redir_pc1", bus.out_pc, 64'h404);

        // misaligned redirect
        drive(0, 1, 64'h403, 1);
        tick();
        check("misalign_addr", bus.imem_addr, 64'h400);
        drive(0, 0, 64'h0, 1);
        tick();
        check("misalign_pc", bus.out_pc, 64'h400);

        // reset beats redirect
        drive(1, 1, 64'h800, 1);
        tick();
        check("prio_addr", bus.imem_addr, RESET_PC);
        check("prio_occ", 64'(bus.occupancy), 64'd0);

        // reset with a full queue
        drive(0, 0, 64'h0, 0);
        for (int i = 0; i < 5; i++) tick();
        check("midrst_full", 64'(bus.occupancy), 64'd4);
        drive(1, 0, 64'h0, 0);
        tick();
        check_reset_outputs("midrst");
        drive(0, 0, 64'h0, 1);
        tick();
        check("midrst_valid", 64'(bus.out_valid), 64'd1);
        check("midrst_pc", bus.out_pc, RESET_PC);

        // predecode of B at 0x8
        drive(1, 0, 64'h0, 1);
        b_at_8 = 1;
        tick();
        drive(0, 0, 64'h0, 1);
        for (int i = 0; i < 3; i++) tick();
        check("pre_b_pc", bus.out_pc, 64'h8);
        check("pre_b_instr", 64'(bus.out_instr), 64'h14000004);
`ifdef FETCH_PREDECODE_B_EN
        check("pre_b_pred", 64'(bus.out_pred_taken), 64'd1);
        tick();
        check("pre_next_pc", bus.out_pc, 64'h18);
`else
        check("pre_b_pred", 64'(bus.out_pred_taken), 64'd0);
        tick();
        check("pre_next_pc", bus.out_pc, 64'hC);
`endif

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            bit r;
            bit rv;
            r  = ($urandom_range(0, 49) == 0);
            rv = !r && ($urandom_range(0, 11) == 0);
            drive(r, rv, 64'($urandom_range(0, 4095)), $urandom_range(0, 9) < 7);
            tick();
        end

        drive(0, 0, 64'h0, 1);
        for (int i = 0; i < 8; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the datapath.
- Holds the PC and reads the instruction memory each cycle. Buffers fetched {pc, instr} pairs in a small circular queue and presents them to decode via a valid/ready handshake.
- Supplies PC+4 as out_basicAddress, which the datapath writes back for BL.
- Accepts a redirect from execute (taken branch / flush) that overrides everything except reset.

Parameters:
- DEPTH, 4, queue entries; power of two, >=2
- RESET_PC, 64'h0, PC value loaded on reset

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high reset
- imem_addr  output  64  instruction memory address; equals current PC, combinational
- imem_rdata  input  32  instruction word at imem_addr, same-cycle combinational read
- redirect_valid  input  1  flush queue and load redirect_pc
- redirect_pc  input  64  new fetch address; bits [1:0] ignored (forced 0)
- out_valid  output  1  head entry valid
- out_ready  input  1  decode accepts head entry this cycle
- out_instr  output  32  head instruction
- out_pc  output  64  head PC
- out_basicAddress  output  64  head PC + 4
- out_pred_taken  output  1  head entry was predicted taken at fetch
- occupancy  output  $clog2(DEPTH+1)  entries currently held

Behaviour:
- **Reset.** Effective on the posedge while reset=1:
  - pc<=RESET_PC; head/tail pointers and count <= 0; all storage cleared.
  - Outputs: out_valid=0, out_instr=0, out_pc=0, out_basicAddress=4, out_pred_taken=0, occupancy=0.
- **pop** = out_valid & out_ready.
- **push** = !reset & !redirect_valid & (count<DEPTH | pop). A full queue with a simultaneous pop still fetches.
- **On push:**
  - entry[tail] <= {pc, imem_rdata, pred}; tail <= tail+1 mod DEPTH.
  - pc <= next_pc, where next_pc = pc+4 (modulo 2^64) unless predicted (see Optional Feature).
- **On pop:** head <= head+1 mod DEPTH.
- **Count:** count <= count + push - pop.
- **No push:** pc holds, so imem_addr is stable while the queue is full.
- **Latency:**
  - Entry fetched in cycle N is visible on out_* in cycle N+1; no same-cycle bypass.
  - After reset deasserts: first fetch is in cycle 0, out_valid=1 in cycle 1.
- **Throughput:** one instruction per cycle sustained with out_ready held high.
- **Redirect** (redirect_valid=1, reset=0):
  - count, head and tail <= 0; pc <= {redirect_pc[63:2],2'b00}.
  - Any pop or push that cycle is discarded, so out_valid=0 the next cycle.
  - The first redirected instruction appears one cycle after that.
- **Priority:** reset > redirect > push/pop.
- **Outputs:** out_* are driven from entry[head] and held stable while out_valid=1 and out_ready=0.
- **Pointer wrap:** pointers wrap with no gap. count never exceeds DEPTH and never underflows; out_valid = (count!=0).

Optional Feature:
- Macro: FETCH_PREDECODE_B_EN.
- **Defined:**
  - If imem_rdata[31:26]==6'b000101 (unconditional B), next_pc = pc + (sign-extend imm26 << 2).
  - The B is still enqueued, with pred_taken=1.
  - Execute must not re-redirect entries carrying out_pred_taken=1.
- **Undefined:** next_pc always pc+4 and out_pred_taken tied 0; the predecode logic is absent.

Decomposition:
- Package fetch_pkg:
  - PC_W=64, INSTR_W=32, OPC_B=6'b000101.
  - typedef fetch_entry_t struct packed {pc, instr, pred_taken}.
- Sub-module fetch_queue: circular FIFO of fetch_entry_t.
  - Ports: push, pop, flush, head entry, count.
  - Instantiated once.
- The PC register and next_pc logic stay in fetch_unit.

Test Plan:
- **Streaming.** Release reset, out_ready=1, imem_rdata = imem_addr[31:0].
  - Expect out_valid from cycle 1, out_pc 0,4,8,C consecutive each cycle.
  - Expect out_basicAddress = out_pc+4 and out_instr = out_pc[31:0].
- **Backpressure.** DEPTH=4, out_ready=0 for 6 cycles.
  - Expect occupancy=4 and imem_addr held at 0x10.
  - Raise out_ready: expect 0,4,8,C,10,14 in order, no bubble, occupancy stays 4 until redirect/end.
- **Redirect.** 3 entries queued, out_ready=1, redirect_valid=1 with redirect_pc=0x400 for one cycle.
  - Next cycle: out_valid=0, occupancy=0.
  - Following cycle: out_pc=0x400, then 0x404.
- **Misaligned redirect / reset priority.**
  - redirect_pc=0x403: expect fetch at 0x400.
  - reset and redirect asserted together: expect pc=RESET_PC.
- **Reset mid-operation.** Full queue, pulse reset one cycle.
  - Expect out_valid=0, occupancy=0 and outputs at reset values next cycle.
  - Then out_pc=RESET_PC one cycle after deassert.
- **Predecode.** Word at 0x8 = 32'h14000004 (B, imm26=4).
  - With FETCH_PREDECODE_B_EN: entry 0x8 has pred_taken=1 and the next out_pc is 0x18.
  - Without it: the next out_pc is 0xC and pred_taken=0.
